// File: rtl/amiga_clk_en_if.sv
// rtl/amiga_clk_en_if.sv - lock input and clock-enable/reset outputs of amiga_clk_en
interface amiga_clk_en_if;
  logic       locked;
  logic       clk7_en;
  logic       clk7n_en;
  logic       c1;
  logic       c3;
  logic       cck;
  logic [9:0] eclk;
  logic       e_out;
  logic       sys_rst;

  modport master (
    output locked,
    input  clk7_en, clk7n_en, c1, c3, cck, eclk, e_out, sys_rst
  );

  modport slave (
    input  locked,
    output clk7_en, clk7n_en, c1, c3, cck, eclk, e_out, sys_rst
  );
endinterface

// File: rtl/amiga_clk_en.sv
// rtl/amiga_clk_en.sv - 28 MHz clock-enable, quadrature phase, E-clock and reset sequencer (option: AMIGA_CLK_ECLK_EN)
module amiga_clk_en #(
  parameter int RST_HOLD = 4096
) (
  input  logic           i_clk28,
  input  logic           i_rst,
  amiga_clk_en_if.slave  io_bus
);

  localparam logic [15:0] HOLD = 16'(RST_HOLD);

  logic [1:0]  r_phase;
  logic [1:0]  w_phase_next;
  logic        r_clk7_en;
  logic        r_clk7n_en;
  logic        r_c1;
  logic        r_c3;
  logic        r_cck;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_lock_ok;
  logic [15:0] r_hold_cnt;
  logic [15:0] w_hold_next;
  logic        r_sys_rst;

  assign w_phase_next = r_phase + 2'd1;

  // Free-running phase counter; strobes and phases decode the next phase so they line up with it
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_phase    <= 2'd0;
      r_clk7_en  <= 1'b0;
      r_clk7n_en <= 1'b0;
      r_c1       <= 1'b0;
      r_c3       <= 1'b0;
    end else begin
      r_phase    <= w_phase_next;
      r_clk7_en  <= (w_phase_next == 2'd3);
      r_clk7n_en <= (w_phase_next == 2'd1);
      r_c1       <= (w_phase_next == 2'd1) || (w_phase_next == 2'd2);
      r_c3       <= (w_phase_next == 2'd2) || (w_phase_next == 2'd3);
    end
  end

  // Colour clock toggles on every 7 MHz strobe
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_cck <= 1'b0;
    end else begin
      r_cck <= r_cck ^ r_clk7_en;
    end
  end

`ifdef AMIGA_CLK_ECLK_EN
  logic [3:0] r_ecnt;
  logic [3:0] w_ecnt_next;
  logic [9:0] r_eclk;
  logic       r_e_out;

  assign w_ecnt_next = !r_clk7_en     ? r_ecnt :
                       (r_ecnt == 4'd9) ? 4'd0   : r_ecnt + 4'd1;

  // Divide-by-10 E-clock counter; one-hot and level outputs decode the next count
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_ecnt  <= 4'd0;
      r_eclk  <= 10'b0000000001;
      r_e_out <= 1'b0;
    end else begin
      r_ecnt  <= w_ecnt_next;
      r_eclk  <= 10'b0000000001 << w_ecnt_next;
      r_e_out <= (w_ecnt_next >= 4'd6);
    end
  end

  assign io_bus.eclk  = r_eclk;
  assign io_bus.e_out = r_e_out;
`else
  assign io_bus.eclk  = 10'b0000000001;
  assign io_bus.e_out = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock flag
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= io_bus.locked;
      r_sync2 <= r_sync1;
    end
  end

  // A low already in the first stage counts as lock loss, so reset reasserts one edge sooner
  assign w_lock_ok   = r_sync1 & r_sync2;
  assign w_hold_next = !w_lock_ok           ? 16'd0      :
                       (r_hold_cnt == HOLD) ? r_hold_cnt : r_hold_cnt + 16'd1;

  // Hold counter: saturates at HOLD while locked, clears on any loss; system reset follows it
  always_ff @(posedge i_clk28) begin
    if (i_rst) begin
      r_hold_cnt <= 16'd0;
      r_sys_rst  <= 1'b1;
    end else begin
      r_hold_cnt <= w_hold_next;
      r_sys_rst  <= !(w_lock_ok && (w_hold_next == HOLD));
    end
  end

  assign io_bus.clk7_en  = r_clk7_en;
  assign io_bus.clk7n_en = r_clk7n_en;
  assign io_bus.c1       = r_c1;
  assign io_bus.c3       = r_c3;
  assign io_bus.cck      = r_cck;
  assign io_bus.sys_rst  = r_sys_rst;

endmodule

// File: tb/tb_amiga_clk_en.sv
// tb/tb_amiga_clk_en.sv - randomized self-checking bench for amiga_clk_en
module tb_amiga_clk_en;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  amiga_clk_en_if bus();

  amiga_clk_en #(.RST_HOLD(HOLD)) dut (
    .i_clk28 (clk),
    .i_rst   (rst),
    .io_bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: m_n = edges since reset released, m_run = consecutive high lock samples
  int   m_n     = 0;
  int   m_run   = 0;
  logic m_sys_rst = 1'b1;
  bit   m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n       = 0;
      m_run     = 0;
      m_sys_rst = 1'b1;
    end else begin
      m_n++;
      m_sys_rst = !(m_run >= HOLD + 1);
      m_run     = bus.locked ? m_run + 1 : 0;
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    int ph;
    int ec;
    logic [9:0] exp_eclk;
    logic       exp_eout;
    #1;
    if (m_valid) begin
      ph = m_n % 4;
      ec = (m_n / 4) % 10;
`ifdef AMIGA_CLK_ECLK_EN
      exp_eclk = 10'd1 << ec;
      exp_eout = (ec >= 6);
`else
      exp_eclk = 10'd1;
      exp_eout = 1'b0;
`endif
      check("clk7_en",  bus.clk7_en,  ph == 3);
      check("clk7n_en", bus.clk7n_en, ph == 1);
      check("c1",       bus.c1,       ph == 1 || ph == 2);
      check("c3",       bus.c3,       ph == 2 || ph == 3);
      check("cck",      bus.cck,      ((m_n / 4) % 2) == 1);
      check("eclk",     bus.eclk,     exp_eclk);
      check("e_out",    bus.e_out,    exp_eout);
      check("sys_rst",  bus.sys_rst,  m_sys_rst);
      if (m_n == 1) check("E1_clk7n_en", bus.clk7n_en, 1);
      if (m_n == 3) check("E3_clk7_en", bus.clk7_en, 1);
      if (m_n == 4) check("E4_cck", bus.cck, 1);
`ifdef AMIGA_CLK_ECLK_EN
      if (m_n == 23) check("E23_e_out", bus.e_out, 0);
      if (m_n == 24) check("E24_e_out", bus.e_out, 1);
      if (m_n == 24) check("E24_eclk", bus.eclk, 10'b0001000000);
`else
      if (m_n == 24) check("E24_e_out", bus.e_out, 0);
`endif
    end
  end

  initial begin
    int t;
    bus.locked = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sys_rst", bus.sys_rst, 1);
    check("rst_eclk",    bus.eclk,    10'b1);
    check("rst_c1",      bus.c1,      0);
    rst = 1'b0;

    t = 0;
    while (m_n != 30 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("wait_n30", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clk7_en", bus.clk7_en, 0);
    check("mid_rst_c3",      bus.c3,      0);
    check("mid_rst_cck",     bus.cck,     0);
    check("mid_rst_eclk",    bus.eclk,    10'b1);
    check("mid_rst_e_out",   bus.e_out,   0);
    check("mid_rst_sys_rst", bus.sys_rst, 1);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    bus.locked = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("lock_L5", bus.sys_rst, 1);
    @(posedge clk);
    #1 check("lock_L6", bus.sys_rst, 0);

    repeat (5) @(negedge clk);
    bus.locked = 1'b0;
    @(posedge clk);
    #1 check("loss_D1", bus.sys_rst, 0);
    @(posedge clk);
    #1 check("loss_D2", bus.sys_rst, 1);
    @(negedge clk);
    @(negedge clk);
    bus.locked = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("relock_H5", bus.sys_rst, 1);
    @(posedge clk);
    #1 check("relock_H6", bus.sys_rst, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 3) bus.locked = ~bus.locked;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
